// File: rtl/axi_read_master_mq_pkg.sv
// Shared constants for the multi-queue AXI read master:
// request word layout, FSM encoding and AXI codes.
package axi_rd_pkg;

  localparam int PROT_LSB  = 0;
  localparam int PROT_W    = 3;
  localparam int CACHE_LSB = 3;
  localparam int CACHE_W   = 4;
  localparam int LOCK_LSB  = 7;
  localparam int LOCK_W    = 2;
  localparam int BURST_LSB = 9;
  localparam int BURST_W   = 2;
  localparam int SIZE_LSB  = 11;
  localparam int SIZE_W    = 2;
  localparam int LEN_LSB   = 13;
  localparam int LEN_W     = 4;
  localparam int ADDR_LSB  = 17;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_VALID = 1'b1
  } ar_state_e;

  function automatic int req_w(int idw, int bw);
    return idw + bw + ADDR_LSB;
  endfunction

endpackage

// File: rtl/axi_read_master_mq_if.sv
// AXI read address and read data channels
// between the read master and the interconnect.
interface axi_read_master_mq_if #(
  parameter int tagbits  = 1,
  parameter int BusWidth = 32
) ();

  logic [tagbits-1:0]  ARID;
  logic [BusWidth-1:0] ARADDR;
  logic [3:0]          ARLEN;
  logic [1:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic [1:0]          ARLOCK;
  logic [3:0]          ARCACHE;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;

  logic [tagbits-1:0]  RID;
  logic [BusWidth-1:0] RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE,
    output ARBURST, ARLOCK, ARCACHE, ARPROT,
    output ARVALID, RREADY,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE,
    input  ARBURST, ARLOCK, ARCACHE, ARPROT,
    input  ARVALID, RREADY,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID
  );

endinterface

// File: rtl/axi_read_master_mq_rd_req_fifo.sv
// Request queue: power-of-two depth, head word
// visible combinationally, push dropped when full.
module rd_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case (1'b1)
      (do_push && !do_pop): cnt_d = cnt_q + 1'b1;
      (do_pop && !do_push): cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/axi_read_master_mq.sv
// Multi-queue AXI read master: round-robin AR issue
// with per-ID burst tracking and R-channel checks.
module axi_read_master_mq
  import axi_rd_pkg::*;
#(
  parameter int NUM_Q      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int BusWidth   = 32,
  parameter int tagbits    = 1,
  localparam int REQ_W     = req_w(tagbits, BusWidth)
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [NUM_Q-1:0]       q_write,
  input  logic [NUM_Q*REQ_W-1:0] q_din,
  output logic [NUM_Q-1:0]       q_full,
  output logic [NUM_Q-1:0]       q_empty,
  axi_read_master_mq_if.master   axi,
  output logic                   rd_valid,
  output logic [tagbits-1:0]     rd_id,
  output logic [BusWidth-1:0]    rd_data,
  output logic [1:0]             rd_resp,
  output logic                   rd_last,
  output logic                   err_unexp,
  output logic                   err_rlast
);

  localparam int QW  = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam int QN  = 1 << QW;
  localparam int NID = 1 << tagbits;
  localparam int IDL = ADDR_LSB + BusWidth;

  logic [REQ_W-1:0] head [QN];
  logic [NUM_Q-1:0] pop;
  logic [QN-1:0]    elig;
  logic             found;
  logic [QW-1:0]    pick;
  logic             ar_hs;
  logic             beat;

  ar_state_e state_q, state_d;

  logic [tagbits-1:0]  arid_q, arid_d;
  logic [BusWidth-1:0] araddr_q, araddr_d;
  logic [3:0]          arlen_q, arlen_d;
  logic [1:0]          arsize_q, arsize_d;
  logic [1:0]          arburst_q, arburst_d;
  logic [1:0]          arlock_q, arlock_d;
  logic [3:0]          arcache_q, arcache_d;
  logic [2:0]          arprot_q, arprot_d;
  logic                arvalid_q, arvalid_d;
  logic [QW-1:0]       sel_q, sel_d;
  logic [QW-1:0]       rr_q, rr_d;
  logic [QW:0]         rr_inc;

  logic [NID-1:0] busy_q, busy_d;
  logic [3:0]     cnt_q [NID];
  logic [3:0]     cnt_d [NID];
  logic [3:0]     exp_q [NID];
  logic [3:0]     exp_d [NID];
  logic           last_exp;

  logic                rdv_q, rdl_q;
  logic [tagbits-1:0]  rdid_q;
  logic [BusWidth-1:0] rddat_q;
  logic [1:0]          rdrsp_q;
  logic                eu_q, eu_d;
  logic                el_q, el_d;

  for (genvar i = 0; i < NUM_Q; i++) begin : g_q
    rd_req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (ACLK),
      .rst_i   (ARESET),
      .push_i  (q_write[i]),
      .din_i   (q_din[i*REQ_W +: REQ_W]),
      .pop_i   (pop[i]),
      .head_o  (head[i]),
      .full_o  (q_full[i]),
      .empty_o (q_empty[i])
    );
  end

  for (genvar i = NUM_Q; i < QN; i++) begin : g_pad
    assign head[i] = '0;
  end

  assign ar_hs = (state_q == AR_VALID) && axi.ARREADY;
  assign beat  = axi.RVALID && axi.RREADY;

  always_comb begin
    for (int k = 0; k < NUM_Q; k++) begin
      pop[k] = ar_hs && (sel_q == QW'(k));
    end
  end

  // eligibility reads registered busy: a freed ID waits one cycle
  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_Q; k++) begin
      elig[k] = !q_empty[k] &&
                !busy_q[head[k][IDL +: tagbits]];
    end
  end

  always_comb begin
    logic [QW:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_Q; k++) begin
      idx = {1'b0, rr_q} + (QW+1)'(k);
      if (idx >= (QW+1)'(NUM_Q)) begin
        idx = idx - (QW+1)'(NUM_Q);
      end
      if (!found && elig[idx[QW-1:0]]) begin
        found = 1'b1;
        pick  = idx[QW-1:0];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= AR_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AR_IDLE:  if (found)       state_d = AR_VALID;
      AR_VALID: if (axi.ARREADY) state_d = AR_IDLE;
      default:                   state_d = AR_IDLE;
    endcase
  end

  assign rr_inc = {1'b0, sel_q} + 1'b1;

  always_comb begin
    logic [REQ_W-1:0] hw;
    hw        = head[pick];
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arlock_d  = arlock_q;
    arcache_d = arcache_q;
    arprot_d  = arprot_q;
    arvalid_d = arvalid_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    unique case (1'b1)
      (state_q == AR_IDLE) && found: begin
        arid_d    = hw[IDL +: tagbits];
        araddr_d  = hw[ADDR_LSB +: BusWidth];
        arlen_d   = hw[LEN_LSB +: LEN_W];
        arsize_d  = hw[SIZE_LSB +: SIZE_W];
        arburst_d = hw[BURST_LSB +: BURST_W];
        arlock_d  = hw[LOCK_LSB +: LOCK_W];
        arcache_d = hw[CACHE_LSB +: CACHE_W];
        arprot_d  = hw[PROT_LSB +: PROT_W];
        arvalid_d = 1'b1;
        sel_d     = pick;
      end
      ar_hs: begin
        arvalid_d = 1'b0;
        rr_d = (rr_inc == (QW+1)'(NUM_Q)) ?
               '0 : rr_inc[QW-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arlock_q  <= '0;
      arcache_q <= '0;
      arprot_q  <= '0;
      arvalid_q <= 1'b0;
      sel_q     <= '0;
      rr_q      <= '0;
    end else begin
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      arlock_q  <= arlock_d;
      arcache_q <= arcache_d;
      arprot_q  <= arprot_d;
      arvalid_q <= arvalid_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
    end
  end

  assign last_exp = (cnt_q[axi.RID] == exp_q[axi.RID]);

  // issue and completion never target the same ID in one cycle
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    exp_d  = exp_q;
    eu_d   = 1'b0;
    el_d   = 1'b0;
    if (beat) begin
      if (!busy_q[axi.RID]) begin
        eu_d = 1'b1;
      end else begin
        el_d = (axi.RLAST != last_exp);
        if (axi.RLAST || last_exp) begin
          busy_d[axi.RID] = 1'b0;
          cnt_d[axi.RID]  = '0;
        end else begin
          cnt_d[axi.RID] = cnt_q[axi.RID] + 1'b1;
        end
      end
    end
    if (ar_hs) begin
      busy_d[arid_q] = 1'b1;
      exp_d[arid_q]  = arlen_q;
      cnt_d[arid_q]  = '0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      busy_q <= '0;
      for (int k = 0; k < NID; k++) begin
        cnt_q[k] <= '0;
        exp_q[k] <= '0;
      end
      rdv_q   <= 1'b0;
      rdid_q  <= '0;
      rddat_q <= '0;
      rdrsp_q <= '0;
      rdl_q   <= 1'b0;
      eu_q    <= 1'b0;
      el_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      exp_q  <= exp_d;
      rdv_q  <= beat;
      eu_q   <= eu_d;
      el_q   <= el_d;
      if (beat) begin
        rdid_q  <= axi.RID;
        rddat_q <= axi.RDATA;
        rdrsp_q <= axi.RRESP;
        rdl_q   <= axi.RLAST;
      end
    end
  end

  assign axi.ARID    = arid_q;
  assign axi.ARADDR  = araddr_q;
  assign axi.ARLEN   = arlen_q;
  assign axi.ARSIZE  = arsize_q;
  assign axi.ARBURST = arburst_q;
  assign axi.ARLOCK  = arlock_q;
  assign axi.ARCACHE = arcache_q;
  assign axi.ARPROT  = arprot_q;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = 1'b1;

  assign rd_valid  = rdv_q;
  assign rd_id     = rdid_q;
  assign rd_data   = rddat_q;
  assign rd_resp   = rdrsp_q;
  assign rd_last   = rdl_q;
  assign err_unexp = eu_q;
  assign err_rlast = el_q;

endmodule

// File: tb/tb_axi_read_master_mq.sv
// Directed bench for axi_read_master_mq with four
// queues, two-bit IDs and hand-computed expectations.
module tb_axi_read_master_mq;

  localparam int NQ = 4;
  localparam int TB = 2;
  localparam int BW = 32;
  localparam int RW = TB + BW + 17;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [NQ-1:0] q_write;
  logic [NQ*RW-1:0] q_din;
  logic [NQ-1:0] q_full, q_empty;
  logic          rd_valid, rd_last;
  logic [TB-1:0] rd_id;
  logic [BW-1:0] rd_data;
  logic [1:0]    rd_resp;
  logic          err_unexp, err_rlast;

  int nvec  = 0;
  int nfail = 0;

  axi_read_master_mq_if #(
    .tagbits  (TB),
    .BusWidth (BW)
  ) axi ();

  axi_read_master_mq #(
    .NUM_Q      (NQ),
    .FIFO_DEPTH (4),
    .BusWidth   (BW),
    .tagbits    (TB)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .q_write   (q_write),
    .q_din     (q_din),
    .q_full    (q_full),
    .q_empty   (q_empty),
    .axi       (axi),
    .rd_valid  (rd_valid),
    .rd_id     (rd_id),
    .rd_data   (rd_data),
    .rd_resp   (rd_resp),
    .rd_last   (rd_last),
    .err_unexp (err_unexp),
    .err_rlast (err_rlast)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [RW-1:0] mkreq(
    logic [TB-1:0] id, logic [BW-1:0] a, logic [3:0] len);
    return {id, a, len, 2'd2, 2'd1, 2'd0, 4'd3, 3'd2};
  endfunction

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(int q, logic [RW-1:0] w);
    q_write = '0;
    q_write[q] = 1'b1;
    q_din[q*RW +: RW] = w;
    step();
    q_write = '0;
  endtask

  task automatic beat(logic [TB-1:0] id,
                      logic [BW-1:0] d, logic last);
    axi.RVALID = 1'b1;
    axi.RID    = id;
    axi.RDATA  = d;
    axi.RRESP  = 2'd0;
    axi.RLAST  = last;
    step();
    axi.RVALID = 1'b0;
    axi.RLAST  = 1'b0;
  endtask

  task automatic chk_err(string tag, logic u, logic l);
    chk({tag, "_unexp"}, 64'(err_unexp), 64'(u));
    chk({tag, "_rlast"}, 64'(err_rlast), 64'(l));
  endtask

  initial begin
    ARESET = 1'b1;
    q_write = '0;
    q_din = '0;
    axi.ARREADY = 1'b0;
    axi.RVALID = 1'b0;
    axi.RID = '0;
    axi.RDATA = '0;
    axi.RRESP = '0;
    axi.RLAST = 1'b0;
    step();
    step();
    chk("rst_empty", 64'(q_empty), 64'hF);
    chk("rst_full", 64'(q_full), 64'h0);
    chk("rst_arvalid", 64'(axi.ARVALID), 64'h0);
    chk("rst_araddr", 64'(axi.ARADDR), 64'h0);
    chk("rst_rready", 64'(axi.RREADY), 64'h1);
    chk("rst_rdvalid", 64'(rd_valid), 64'h0);
    chk_err("rst", 1'b0, 1'b0);

    ARESET = 1'b0;
    axi.ARREADY = 1'b1;
    push(0, mkreq(2'd0, 32'h1000, 4'd3));
    chk("t1_lat1", 64'(axi.ARVALID), 64'h0);
    chk("t1_head", 64'(q_empty[0]), 64'h0);
    step();
    chk("t1_arvalid", 64'(axi.ARVALID), 64'h1);
    chk("t1_arid", 64'(axi.ARID), 64'h0);
    chk("t1_araddr", 64'(axi.ARADDR), 64'h1000);
    chk("t1_arlen", 64'(axi.ARLEN), 64'h3);
    chk("t1_arsize", 64'(axi.ARSIZE), 64'h2);
    chk("t1_arburst", 64'(axi.ARBURST), 64'h1);
    chk("t1_arlock", 64'(axi.ARLOCK), 64'h0);
    chk("t1_arcache", 64'(axi.ARCACHE), 64'h3);
    chk("t1_arprot", 64'(axi.ARPROT), 64'h2);
    step();
    chk("t1_hs", 64'(axi.ARVALID), 64'h0);
    chk("t1_pop", 64'(q_empty[0]), 64'h1);
    for (int k = 0; k < 4; k++) begin
      beat(2'd0, 32'hA0 + k, k == 3);
      chk("t1_rdv", 64'(rd_valid), 64'h1);
      chk("t1_rdd", 64'(rd_data), 64'hA0 + k);
      chk("t1_rdl", 64'(rd_last), 64'(k == 3));
      chk_err("t1", 1'b0, 1'b0);
    end
    step();
    chk("t1_rdv_end", 64'(rd_valid), 64'h0);
    beat(2'd0, 32'h0, 1'b1);
    chk_err("t1_freed", 1'b1, 1'b0);
    step();
    chk_err("t1_pulse", 1'b0, 1'b0);

    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    q_write = 4'hF;
    q_din = {mkreq(2'd3, 32'h400, 4'd0),
             mkreq(2'd2, 32'h300, 4'd0),
             mkreq(2'd1, 32'h200, 4'd0),
             mkreq(2'd0, 32'h100, 4'd0)};
    step();
    q_write = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_arvalid", 64'(axi.ARVALID), 64'h1);
      chk("rr_arid", 64'(axi.ARID), 64'(i));
      chk("rr_araddr", 64'(axi.ARADDR), 64'(32'h100 * (i + 1)));
      step();
      chk("rr_gap", 64'(axi.ARVALID), 64'h0);
    end
    for (int i = 0; i < 4; i++) begin
      beat(2'(i), 32'(i), 1'b1);
      chk_err("rr_done", 1'b0, 1'b0);
    end
    q_write = 4'b0011;
    q_din[0 +: RW] = mkreq(2'd0, 32'h500, 4'd0);
    q_din[RW +: RW] = mkreq(2'd1, 32'h600, 4'd0);
    step();
    q_write = '0;
    step();
    chk("rr_wrap0", 64'(axi.ARADDR), 64'h500);
    chk("rr_wrap0v", 64'(axi.ARVALID), 64'h1);
    step();
    step();
    chk("rr_wrap1", 64'(axi.ARADDR), 64'h600);
    chk("rr_wrap1v", 64'(axi.ARVALID), 64'h1);
    step();
    beat(2'd0, 32'h0, 1'b1);
    chk_err("rr_c0", 1'b0, 1'b0);
    beat(2'd1, 32'h0, 1'b1);
    chk_err("rr_c1", 1'b0, 1'b0);

    axi.ARREADY = 1'b0;
    push(2, mkreq(2'd2, 32'h2000, 4'd1));
    step();
    chk("st_arvalid", 64'(axi.ARVALID), 64'h1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("st_hold_v", 64'(axi.ARVALID), 64'h1);
      chk("st_hold_a", 64'(axi.ARADDR), 64'h2000);
      chk("st_hold_l", 64'(axi.ARLEN), 64'h1);
      chk("st_nopop", 64'(q_empty[2]), 64'h0);
    end
    axi.ARREADY = 1'b1;
    step();
    chk("st_hs", 64'(axi.ARVALID), 64'h0);
    chk("st_pop", 64'(q_empty[2]), 64'h1);
    beat(2'd2, 32'h1, 1'b0);
    chk_err("st_b0", 1'b0, 1'b0);
    beat(2'd2, 32'h2, 1'b1);
    chk_err("st_b1", 1'b0, 1'b0);

    q_write = 4'b0011;
    q_din[0 +: RW] = mkreq(2'd1, 32'h3000, 4'd1);
    q_din[RW +: RW] = mkreq(2'd1, 32'h3100, 4'd0);
    step();
    q_write = '0;
    step();
    chk("id_q0", 64'(axi.ARADDR), 64'h3000);
    chk("id_q0v", 64'(axi.ARVALID), 64'h1);
    step();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("id_block", 64'(axi.ARVALID), 64'h0);
    end
    beat(2'd1, 32'h0, 1'b0);
    chk("id_block_b0", 64'(axi.ARVALID), 64'h0);
    beat(2'd1, 32'h1, 1'b1);
    chk("id_block_b1", 64'(axi.ARVALID), 64'h0);
    chk_err("id_b1", 1'b0, 1'b0);
    step();
    chk("id_q1v", 64'(axi.ARVALID), 64'h1);
    chk("id_q1a", 64'(axi.ARADDR), 64'h3100);
    step();
    beat(2'd1, 32'h0, 1'b1);
    chk_err("id_done", 1'b0, 1'b0);

    push(2, mkreq(2'd3, 32'h4000, 4'd3));
    step();
    chk("er_arv", 64'(axi.ARVALID), 64'h1);
    step();
    beat(2'd3, 32'h0, 1'b0);
    chk_err("er_b0", 1'b0, 1'b0);
    beat(2'd3, 32'h1, 1'b1);
    chk_err("er_early", 1'b0, 1'b1);
    beat(2'd3, 32'h2, 1'b0);
    chk_err("er_freed", 1'b1, 1'b0);
    push(3, mkreq(2'd0, 32'h4100, 4'd0));
    step();
    step();
    beat(2'd0, 32'h0, 1'b0);
    chk_err("er_missing", 1'b0, 1'b1);
    beat(2'd0, 32'h0, 1'b1);
    chk_err("er_freed2", 1'b1, 1'b0);
    step();
    chk_err("er_pulse", 1'b0, 1'b0);
    beat(2'd1, 32'h77, 1'b0);
    chk_err("er_idle", 1'b1, 1'b0);
    chk("er_rdid", 64'(rd_id), 64'h1);

    axi.ARREADY = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(1, mkreq(2'(k), 32'hA0 + k, 4'd0));
      chk("fl_full", 64'(q_full[1]), 64'(k == 3));
    end
    push(1, mkreq(2'd0, 32'hDEAD, 4'd0));
    chk("fl_drop_full", 64'(q_full[1]), 64'h1);
    chk("fl_head_v", 64'(axi.ARVALID), 64'h1);
    chk("fl_head_a", 64'(axi.ARADDR), 64'hA0);
    axi.ARREADY = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      chk("fl_gap", 64'(axi.ARVALID), 64'h0);
      step();
      chk("fl_v", 64'(axi.ARVALID), 64'h1);
      chk("fl_a", 64'(axi.ARADDR), 64'(32'hA0 + k));
    end
    step();
    step();
    chk("fl_nomore", 64'(axi.ARVALID), 64'h0);
    chk("fl_empty", 64'(q_empty[1]), 64'h1);

    axi.ARREADY = 1'b0;
    push(0, mkreq(2'd0, 32'h5000, 4'd1));
    push(0, mkreq(2'd1, 32'h5100, 4'd1));
    chk("rs_pre_empty", 64'(q_empty), 64'hE);
    chk("rs_pre_arv", 64'(axi.ARVALID), 64'h0);
    ARESET = 1'b1;
    step();
    chk("rs_empty", 64'(q_empty), 64'hF);
    chk("rs_full", 64'(q_full), 64'h0);
    chk("rs_arvalid", 64'(axi.ARVALID), 64'h0);
    chk("rs_arid", 64'(axi.ARID), 64'h0);
    chk("rs_araddr", 64'(axi.ARADDR), 64'h0);
    chk("rs_rdvalid", 64'(rd_valid), 64'h0);
    chk("rs_rddata", 64'(rd_data), 64'h0);
    chk("rs_rready", 64'(axi.RREADY), 64'h1);
    chk_err("rs", 1'b0, 1'b0);
    ARESET = 1'b0;
    beat(2'd2, 32'h9, 1'b1);
    chk_err("rs_after", 1'b1, 1'b0);
    step();
    chk("rs_idle", 64'(axi.ARVALID), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
